// File: rtl/dem_switch_tree_if.sv
// Sample bus between the quantizer and the DEM switching tree.
// valid_i marks x_i/mode_i as a sample this cycle. There is no ready and the tree always accepts.
// valid_o marks elem_o as a new sample. elem_o holds its last value while valid_o is low.
interface dem_switch_tree_if #(
  parameter int LEVELS = 3
) ();
  localparam int N = 1 << LEVELS;

  logic              valid_i;
  logic [LEVELS:0]   x_i;
  logic              mode_i;
  logic              valid_o;
  logic [N-1:0]      elem_o;
  logic              ovf_o;

  modport master (
    output valid_i, x_i, mode_i,
    input  valid_o, elem_o, ovf_o
  );

  modport slave (
    input  valid_i, x_i, mode_i,
    output valid_o, elem_o, ovf_o
  );
endinterface

// File: rtl/dem_switch_tree.sv
// Pipelined binary tree of DEM switching cells: splits an element count into a
// unit-element enable vector using PN-random or first-order noise-shaped steering.
module dem_switch_tree #(
  parameter int          LEVELS    = 3,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic             clk_i,
  input  logic             reset_i,
  dem_switch_tree_if.slave bus
);
  localparam int N  = 1 << LEVELS;
  localparam int W  = LEVELS + 1;
  localparam int NC = N - 1;

  typedef logic [W-1:0] val_t;

  // st_val_q[k][m] holds output m of tree level k; the leaf level is elem_o.
  logic [31:0]       lfsr_q, lfsr_d;
  logic [1:0]        acc_q [NC];
  logic [1:0]        acc_d [NC];
  val_t              st_val_q [LEVELS][N];
  val_t              st_val_d [LEVELS][N];
  logic [LEVELS-1:0] st_vld_q, st_vld_d;
  logic [LEVELS-1:0] st_mode_q, st_mode_d;
  logic              ovf_q, ovf_d;

  val_t              x_sat;
  val_t              cell_in [LEVELS][N/2];
  logic              cell_vld [LEVELS];
  logic              cell_mode [LEVELS];
  val_t              cx, top, bot;
  logic              odd, s_pos;
  int                cj;
  logic [N-1:0]      elem;

  always_comb begin
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    x_sat  = (bus.x_i > val_t'(N)) ? val_t'(N) : bus.x_i;
    ovf_d  = ovf_q | (bus.valid_i & (bus.x_i > val_t'(N)));

    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < N/2; i++) cell_in[k][i] = '0;
      cell_vld[k]  = 1'b0;
      cell_mode[k] = 1'b0;
    end
    cell_in[0][0] = x_sat;
    cell_vld[0]   = bus.valid_i;
    cell_mode[0]  = bus.mode_i;
    for (int k = 1; k < LEVELS; k++) begin
      for (int i = 0; i < N/2; i++) cell_in[k][i] = st_val_q[k-1][i];
      cell_vld[k]  = st_vld_q[k-1];
      cell_mode[k] = st_mode_q[k-1];
    end

    acc_d     = acc_q;
    st_val_d  = st_val_q;
    st_vld_d  = '0;
    st_mode_d = st_mode_q;
    cx = '0; top = '0; bot = '0; odd = 1'b0; s_pos = 1'b0; cj = 0;

    for (int k = 0; k < LEVELS; k++) begin
      st_vld_d[k] = cell_vld[k];
      if (cell_vld[k]) st_mode_d[k] = cell_mode[k];
      for (int i = 0; i < N/2; i++) begin
        if (i < (1 << k)) begin
          cj  = (1 << k) - 1 + i;
          cx  = cell_in[k][i];
          odd = cx[0];
          // acc encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; s_pos selects s=+1.
          if (cell_mode[k] && acc_q[cj] == 2'b01)      s_pos = 1'b0;
          else if (cell_mode[k] && acc_q[cj] == 2'b11) s_pos = 1'b1;
          else                                         s_pos = lfsr_q[cj];
          top = (cx >> 1) + val_t'(odd & s_pos);
          bot = (cx >> 1) + val_t'(odd & ~s_pos);
          if (cell_vld[k]) begin
            st_val_d[k][2*i]   = top;
            st_val_d[k][2*i+1] = bot;
            if (cell_mode[k] && odd) acc_d[cj] = acc_q[cj] + (s_pos ? 2'b01 : 2'b11);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      lfsr_q    <= LFSR_SEED;
      st_vld_q  <= '0;
      st_mode_q <= '0;
      ovf_q     <= 1'b0;
      for (int j = 0; j < NC; j++) acc_q[j] <= '0;
      for (int k = 0; k < LEVELS; k++)
        for (int m = 0; m < N; m++) st_val_q[k][m] <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      st_vld_q  <= st_vld_d;
      st_mode_q <= st_mode_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      st_val_q  <= st_val_d;
    end
  end

  always_comb begin
    elem = '0;
    for (int m = 0; m < N; m++) elem[m] = st_val_q[LEVELS-1][m][0];
  end

  assign bus.elem_o  = elem;
  assign bus.valid_o = st_vld_q[LEVELS-1];
  assign bus.ovf_o   = ovf_q;
endmodule

// File: doc/dem_switch_tree.md
Name: dem_switch_tree

Overview:
- Parametrised successor to the single switching block in the DEM-DAC path.
- Pipelined binary tree of switching cells. Splits a quantizer code (count 0..2^LEVELS) into a 2^LEVELS-bit unit-element vector that drives the DAC.
- Per-cell steering selectable per sample: PN-randomised (mode 0) or first-order noise-shaped (mode 1).
- Sits between the quantizer output and the unit-element DAC array.

Parameters:
- LEVELS, 3, number of tree levels; N = 2^LEVELS unit elements; legal range 1..5.
- LFSR_SEED, 32'hACE1_1234, reset value of the PN LFSR; must be non-zero.

Ports:
- clk_i  input  1  single clock.
- reset_i  input  1  synchronous, active-low reset.
- valid_i  input  1  x_i and mode_i are valid this cycle.
- x_i  input  LEVELS+1  unsigned element count; legal values 0..N.
- mode_i  input  1  0 = PN-random steering, 1 = noise-shaped steering; travels with the sample.
- valid_o  output  1  elem_o holds a new sample.
- elem_o  output  N  unit-element enables; popcount equals the saturated x_i.
- ovf_o  output  1  sticky flag, set when x_i > N was accepted.

Behaviour:
- Reset (reset_i=0 at a posedge):
  - LFSR <= LFSR_SEED.
  - All stage valids, valid_o, elem_o and ovf_o <= 0.
  - Every cell accumulator acc <= 0.
  - Reset asserted mid-stream flushes all in-flight samples; nothing is emitted for them.
- LFSR:
  - 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - Shifts every clock cycle out of reset, independent of valid_i.
  - Cell id j uses LFSR bit j (current state) as its PN bit p.
- Tree structure:
  - Cell ids use heap order: level k, index i -> j = 2^k-1+i.
  - Level k has 2^k cells. Each cell input is LEVELS+1-k bits wide with capacity C = 2^(LEVELS-k).
- Cell function, input x:
  - If x is even: s = 0.
  - If x is odd:
    - mode 0: s = p ? +1 : -1.
    - mode 1: s = (acc==+1) ? -1 : (acc==-1) ? +1 : (p ? +1 : -1).
  - Outputs: top = (x+s)/2 goes to child 2i; bottom = (x-s)/2 goes to child 2i+1. Both are exact integers and never exceed C/2.
  - Leaf level: top/bottom drive elem_o bits 2i / 2i+1.
- Accumulator:
  - Per-cell signed 2-bit, range {-1,0,+1}.
  - acc <= acc + s, updated only when that cell's stage holds a valid sample and mode=1.
  - In mode 0, acc holds its value; switching modes resumes from the stored acc.
- Input stage:
  - x_i > N is saturated to N before level 0, and ovf_o <= 1 in the same cycle (sticky until reset).
  - valid_i=0 inserts a bubble; no cell state updates.
- Pipeline:
  - One register stage per level; sample, mode and valid advance together.
  - Level 0 is evaluated combinationally from x_i in the acceptance cycle.
  - Latency: sample accepted at edge t appears on elem_o/valid_o after edge t+LEVELS-1, i.e. visible LEVELS cycles after valid_i was presented.
  - Full throughput: one sample per cycle, no backpressure.
  - elem_o holds its last value while valid_o=0.
- Invariant: popcount(elem_o) == min(x, N) for every valid_o=1.
- Back-to-back samples use the same cell in consecutive cycles. acc updates must be visible to the following sample: acc is read-modify-write within one cycle, with no stale read.

Test Plan:
1. Reset: hold reset_i=0 for 3 cycles with valid_i=1, x_i=5 -> valid_o=0, elem_o=0, ovf_o=0 throughout; first valid_o exactly 3 cycles (LEVELS=3) after release with valid_i=1.
2. Extremes, LEVELS=3: x_i=0 -> elem_o=8'h00; x_i=8 -> elem_o=8'hFF, both modes, both on consecutive cycles; valid_o aligned to latency 3.
3. Random stream: 10k samples with random x_i in 0..8, random mode_i and random bubbles -> popcount(elem_o) equals the input in order; bubble pattern preserved on valid_o; matches a cycle-exact reference model of LFSR and acc.
4. Noise shaping, mode 1: constant x_i=1 -> root acc alternates; the active element alternates between elem_o[3:0] and elem_o[7:4] every sample; each element is used exactly once per 8 samples after settling.
5. Saturation: x_i=15 -> elem_o=8'hFF, ovf_o=1 and stays 1 after x_i returns to 3; a reset clears it.
6. Mid-stream reset: 4 valid samples, reset_i=0 for 1 cycle at cycle 2 -> no valid_o for the flushed samples; acc and LFSR restart from seed (first post-reset output equals that of the cold-start run).
